// File: rtl/timer_pit_wdog_ctl_if.sv
// SPR write path into the timer sequencer. It carries the mtSPR PIT strobe
// with its data and the TSR write-1-to-clear strobes.
interface timer_pit_wdog_ctl_if #(
  parameter int PIT_WIDTH = 32
);
  logic                 mtPit;
  logic [PIT_WIDTH-1:0] sprData;
  logic [3:0]           tsrClr;

  modport master (output mtPit, output sprData, output tsrClr);
  modport slave  (input  mtPit, input  sprData, input  tsrClr);
endinterface

// File: rtl/timer_pit_wdog_ctl.sv
// Event-timer sequencer: the PIT decrementer with auto-reload, the two-stage
// watchdog and the TSR status bits that raise interrupt and reset requests.
module timer_pit_wdog_ctl #(
  parameter int PIT_WIDTH = 32,
  parameter int RST_PULSE = 16
) (
  input  logic                 CB,
  input  logic                 resetCore,
  input  logic                 timerTic,
  input  logic                 freezeTimersNEG,
  input  logic [3:0]           tbTap,
  input  logic [1:0]           tcrWp,
  input  logic [1:0]           tcrWrc,
  input  logic                 tcrWie,
  input  logic                 tcrPie,
  input  logic                 tcrAre,
  timer_pit_wdog_ctl_if.slave  sprBus,
  output logic [PIT_WIDTH-1:0] pitL2,
  output logic                 tsrEnw,
  output logic                 tsrWis,
  output logic                 tsrPis,
  output logic [1:0]           tsrWrs,
  output logic                 pitIrq,
  output logic                 wdIrq,
  output logic [1:0]           wdRstReq
);

  localparam int CNT_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  // Watchdog state is literally {ENW, WIS}; each bit is also a clearable TSR bit.
  typedef enum logic [1:0] {
    WD_IDLE     = 2'b00,
    WD_WIS_ONLY = 2'b01,
    WD_ENW      = 2'b10,
    WD_BOTH     = 2'b11
  } wdState_t;

  wdState_t             wdState;
  logic [PIT_WIDTH-1:0] pitReload;
  logic [3:0]           tapPrev;
  logic [CNT_W-1:0]     pulseCnt;
  logic                 pitDec;
  logic                 pitExpire;
  logic                 wdEvent;
  logic                 pulseActive;
  logic                 enwNext;
  logic                 wisNext;
  logic                 rstFire;

  always_comb begin
    pitDec      = timerTic & freezeTimersNEG & (pitL2 != '0) & ~sprBus.mtPit;
    pitExpire   = pitDec & (pitL2 == PIT_WIDTH'(1));
    wdEvent     = tbTap[tcrWp] & ~tapPrev[tcrWp];
    pulseActive = (wdRstReq != 2'b00);
  end

  // A watchdog set event overrides a coincident clear of the same bit.
  always_comb begin
    enwNext = tsrEnw & ~sprBus.tsrClr[3];
    wisNext = tsrWis & ~sprBus.tsrClr[2];
    rstFire = 1'b0;
    if (wdEvent && !pulseActive) begin
      case (wdState)
        WD_IDLE, WD_WIS_ONLY: enwNext = 1'b1;
        WD_ENW:               wisNext = 1'b1;
        WD_BOTH:              rstFire = (tcrWrc != 2'b00);
        default:              rstFire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CB) begin
    if (resetCore) begin
      pitL2     <= '0;
      pitReload <= '0;
      tsrPis    <= 1'b0;
      tapPrev   <= tbTap;
    end else begin
      tapPrev <= tbTap;
      if (sprBus.mtPit) begin
        pitL2     <= sprBus.sprData;
        pitReload <= sprBus.sprData;
      end else if (pitDec) begin
        pitL2 <= (pitExpire && tcrAre) ? pitReload : pitL2 - PIT_WIDTH'(1);
      end
      if (pitExpire) begin
        tsrPis <= 1'b1;
      end else if (sprBus.tsrClr[1]) begin
        tsrPis <= 1'b0;
      end
    end
  end

  // The reset pulse runs for RST_PULSE cycles: load RST_PULSE-1, drop wdRstReq after hitting 0.
  always_ff @(posedge CB) begin
    if (resetCore) begin
      wdState  <= WD_IDLE;
      tsrWrs   <= 2'b00;
      wdRstReq <= 2'b00;
      pulseCnt <= '0;
    end else begin
      wdState <= wdState_t'({enwNext, wisNext});
      if (rstFire) begin
        tsrWrs   <= tcrWrc;
        wdRstReq <= tcrWrc;
        pulseCnt <= CNT_W'(RST_PULSE - 1);
      end else begin
        if (sprBus.tsrClr[0]) begin
          tsrWrs <= 2'b00;
        end
        if (pulseActive) begin
          if (pulseCnt != '0) begin
            pulseCnt <= pulseCnt - CNT_W'(1);
          end else begin
            wdRstReq <= 2'b00;
          end
        end
      end
    end
  end

  assign tsrEnw = wdState[1];
  assign tsrWis = wdState[0];
  assign pitIrq = tsrPis & tcrPie;
  assign wdIrq  = tsrWis & tcrWie;

endmodule

// File: tb/tb_timer_pit_wdog_ctl.sv
// Bench for timer_pit_wdog_ctl: directed PIT and watchdog scenarios, with a
// cycle-by-cycle comparison against a behavioural model of the timer rules.
module tb_timer_pit_wdog_ctl;

  localparam int PW = 32;
  localparam int RP = 16;

  logic          CB = 1'b0;
  logic          resetCore;
  logic          timerTic;
  logic          freezeTimersNEG;
  logic [3:0]    tbTap;
  logic [1:0]    tcrWp;
  logic [1:0]    tcrWrc;
  logic          tcrWie;
  logic          tcrPie;
  logic          tcrAre;
  logic [PW-1:0] pitL2;
  logic          tsrEnw;
  logic          tsrWis;
  logic          tsrPis;
  logic [1:0]    tsrWrs;
  logic          pitIrq;
  logic          wdIrq;
  logic [1:0]    wdRstReq;

  int checks = 0;
  int errors = 0;

  timer_pit_wdog_ctl_if #(.PIT_WIDTH(PW)) sprBus ();

  timer_pit_wdog_ctl #(.PIT_WIDTH(PW), .RST_PULSE(RP)) dut (
    .CB              (CB),
    .resetCore       (resetCore),
    .timerTic        (timerTic),
    .freezeTimersNEG (freezeTimersNEG),
    .tbTap           (tbTap),
    .tcrWp           (tcrWp),
    .tcrWrc          (tcrWrc),
    .tcrWie          (tcrWie),
    .tcrPie          (tcrPie),
    .tcrAre          (tcrAre),
    .sprBus          (sprBus.slave),
    .pitL2           (pitL2),
    .tsrEnw          (tsrEnw),
    .tsrWis          (tsrWis),
    .tsrPis          (tsrPis),
    .tsrWrs          (tsrWrs),
    .pitIrq          (pitIrq),
    .wdIrq           (wdIrq),
    .wdRstReq        (wdRstReq)
  );

  always #5 CB = ~CB;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge CB);
    #3;
  endtask

  task automatic toggleTap(input int idx);
    tbTap[idx] = 1'b1;
    applyStimulus(1);
    tbTap[idx] = 1'b0;
    applyStimulus(1);
  endtask

  // Model: PIT value, TSR bits, and the reset pulse as "cycles left to assert".
  logic [PW-1:0] mPit;
  logic [PW-1:0] mReload;
  bit            mEnw;
  bit            mWis;
  bit            mPis;
  bit [1:0]      mWrs;
  bit [1:0]      mRstType;
  int            mRstLeft;
  bit [3:0]      mTapPrev;
  bit            modelValid = 1'b0;
  bit            mEv;
  bit            mActive;
  bit            mPisSet;
  bit            mFire;
  bit            mNewEnw;
  bit            mNewWis;

  always @(posedge CB) begin
    if (resetCore) begin
      mPit       = '0;
      mReload    = '0;
      mEnw       = 1'b0;
      mWis       = 1'b0;
      mPis       = 1'b0;
      mWrs       = 2'b00;
      mRstType   = 2'b00;
      mRstLeft   = 0;
      mTapPrev   = tbTap;
      modelValid = 1'b1;
    end else begin
      mEv      = tbTap[tcrWp] && !mTapPrev[tcrWp];
      mTapPrev = tbTap;
      mActive  = (mRstLeft > 0);
      mPisSet  = 1'b0;
      if (sprBus.mtPit) begin
        mPit    = sprBus.sprData;
        mReload = sprBus.sprData;
      end else if (timerTic && freezeTimersNEG && mPit > 0) begin
        if (mPit == 1) begin
          mPisSet = 1'b1;
          mPit    = tcrAre ? mReload : '0;
        end else begin
          mPit = mPit - 1;
        end
      end
      if (mPisSet) mPis = 1'b1;
      else if (sprBus.tsrClr[1]) mPis = 1'b0;

      mNewEnw = mEnw && !sprBus.tsrClr[3];
      mNewWis = mWis && !sprBus.tsrClr[2];
      mFire   = 1'b0;
      if (mEv && !mActive) begin
        if (!mEnw) mNewEnw = 1'b1;
        else if (!mWis) mNewWis = 1'b1;
        else if (tcrWrc != 2'b00) mFire = 1'b1;
      end
      mEnw = mNewEnw;
      mWis = mNewWis;
      if (mActive) mRstLeft--;
      if (mFire) begin
        mRstLeft = RP;
        mRstType = tcrWrc;
        mWrs     = tcrWrc;
      end else if (sprBus.tsrClr[0]) begin
        mWrs = 2'b00;
      end
    end
  end

  always @(negedge CB) begin
    #1;
    if (modelValid) begin
      checkOutput("cmpPitL2", pitL2, mPit);
      checkOutput("cmpEnw", 32'(tsrEnw), 32'(mEnw));
      checkOutput("cmpWis", 32'(tsrWis), 32'(mWis));
      checkOutput("cmpPis", 32'(tsrPis), 32'(mPis));
      checkOutput("cmpWrs", 32'(tsrWrs), 32'(mWrs));
      checkOutput("cmpPitIrq", 32'(pitIrq), 32'(mPis && tcrPie));
      checkOutput("cmpWdIrq", 32'(wdIrq), 32'(mWis && tcrWie));
      checkOutput("cmpRstReq", 32'(wdRstReq), 32'((mRstLeft > 0) ? mRstType : 2'b00));
    end
  end

  initial begin
    int n;
    resetCore       = 1'b1;
    timerTic        = 1'b0;
    freezeTimersNEG = 1'b1;
    tbTap           = 4'b0000;
    tcrWp           = 2'b00;
    tcrWrc          = 2'b00;
    tcrWie          = 1'b0;
    tcrPie          = 1'b0;
    tcrAre          = 1'b0;
    sprBus.mtPit    = 1'b0;
    sprBus.sprData  = '0;
    sprBus.tsrClr   = 4'b0000;
    applyStimulus(2);
    resetCore = 1'b0;
    checkOutput("rstPit", pitL2, 0);
    checkOutput("rstRstReq", 32'(wdRstReq), 0);
    checkOutput("rstPitIrq", 32'(pitIrq), 0);

    $display("[TB] PIT one-shot countdown");
    sprBus.sprData = 3;
    sprBus.mtPit   = 1'b1;
    applyStimulus(1);
    sprBus.mtPit = 1'b0;
    checkOutput("loadPit3", pitL2, 3);
    for (int k = 2; k >= 0; k--) begin
      timerTic = 1'b1;
      applyStimulus(1);
      timerTic = 1'b0;
      checkOutput("pitDec", pitL2, 32'(k));
      applyStimulus(3);
    end
    checkOutput("pisOnExpire", 32'(tsrPis), 1);
    checkOutput("pitIrqMasked", 32'(pitIrq), 0);
    tcrPie = 1'b1;
    applyStimulus(1);
    checkOutput("pitIrqEnabled", 32'(pitIrq), 1);
    timerTic = 1'b1;
    applyStimulus(3);
    timerTic = 1'b0;
    checkOutput("pitStuckZero", pitL2, 0);
    sprBus.tsrClr = 4'b0010;
    applyStimulus(1);
    sprBus.tsrClr = 4'b0000;
    checkOutput("pisCleared", 32'(tsrPis), 0);

    $display("[TB] PIT auto-reload");
    tcrAre         = 1'b1;
    sprBus.sprData = 2;
    sprBus.mtPit   = 1'b1;
    applyStimulus(1);
    sprBus.mtPit = 1'b0;
    timerTic     = 1'b1;
    applyStimulus(1);
    checkOutput("arePit1", pitL2, 1);
    applyStimulus(1);
    checkOutput("areReload", pitL2, 2);
    checkOutput("arePisSet", 32'(tsrPis), 1);
    sprBus.tsrClr = 4'b0010;
    applyStimulus(1);
    checkOutput("arePisClr", 32'(tsrPis), 0);
    applyStimulus(1);
    sprBus.tsrClr = 4'b0000;
    checkOutput("setBeatsClr", 32'(tsrPis), 1);
    checkOutput("areReload2", pitL2, 2);
    timerTic = 1'b0;
    tcrAre   = 1'b0;

    $display("[TB] freeze");
    freezeTimersNEG = 1'b0;
    timerTic        = 1'b1;
    applyStimulus(4);
    checkOutput("frozenPit", pitL2, 2);
    sprBus.sprData = 7;
    sprBus.mtPit   = 1'b1;
    applyStimulus(1);
    sprBus.mtPit = 1'b0;
    applyStimulus(2);
    checkOutput("frozenLoad", pitL2, 7);
    freezeTimersNEG = 1'b1;
    timerTic        = 1'b0;
    sprBus.tsrClr   = 4'b0010;
    applyStimulus(1);
    sprBus.tsrClr = 4'b0000;

    $display("[TB] watchdog sequence");
    tcrWp  = 2'b01;
    tcrWrc = 2'b10;
    tcrWie = 1'b1;
    toggleTap(1);
    checkOutput("wdEnw", 32'(tsrEnw), 1);
    checkOutput("wdWisClear", 32'(tsrWis), 0);
    toggleTap(1);
    checkOutput("wdWis", 32'(tsrWis), 1);
    checkOutput("wdIrq", 32'(wdIrq), 1);
    tbTap[1] = 1'b1;
    applyStimulus(1);
    tbTap[1] = 1'b0;
    checkOutput("wdFire", 32'(wdRstReq), 2);
    n = 1;
    for (int i = 0; i < 40 && wdRstReq == 2'b10; i++) begin
      if (i == 3) tbTap[1] = 1'b1;
      if (i == 5) tbTap[1] = 1'b0;
      applyStimulus(1);
      if (wdRstReq == 2'b10) n++;
    end
    checkOutput("pulseLen", 32'(n), RP);
    checkOutput("pulseEnd", 32'(wdRstReq), 0);
    checkOutput("wrsHeld", 32'(tsrWrs), 2);

    $display("[TB] tap select change");
    sprBus.tsrClr = 4'b1100;
    applyStimulus(1);
    sprBus.tsrClr = 4'b0000;
    checkOutput("enwCleared", 32'(tsrEnw), 0);
    tbTap = 4'b1000;
    applyStimulus(2);
    tcrWp = 2'b11;
    applyStimulus(2);
    checkOutput("noFalseEvent", 32'(tsrEnw), 0);
    toggleTap(0);
    toggleTap(0);
    checkOutput("otherTapIgnored", 32'(tsrEnw), 0);

    $display("[TB] reset mid pulse");
    sprBus.sprData = 5;
    sprBus.mtPit   = 1'b1;
    applyStimulus(1);
    sprBus.mtPit = 1'b0;
    checkOutput("loadPit5", pitL2, 5);
    for (int e = 0; e < 3; e++) begin
      tbTap[3] = 1'b0;
      applyStimulus(1);
      tbTap[3] = 1'b1;
      applyStimulus(1);
    end
    applyStimulus(2);
    checkOutput("midPulse", 32'(wdRstReq), 2);
    resetCore = 1'b1;
    applyStimulus(1);
    checkOutput("rst2Pit", pitL2, 0);
    checkOutput("rst2Enw", 32'(tsrEnw), 0);
    checkOutput("rst2Wis", 32'(tsrWis), 0);
    checkOutput("rst2Wrs", 32'(tsrWrs), 0);
    checkOutput("rst2RstReq", 32'(wdRstReq), 0);
    checkOutput("rst2WdIrq", 32'(wdIrq), 0);
    resetCore = 1'b0;
    applyStimulus(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_pit_wdog_ctl.md
Name: timer_pit_wdog_ctl

Overview:
Sequencer for the timer facility's event timers. It sits beside the time-base low/high equations.
- Drives the Programmable Interval Timer (PIT): a decrementer with auto-reload, paced by the same oscillator tic and freeze qualifier as the time base.
- Runs the two-stage watchdog state machine, clocked by time-base tap-bit rising edges.
- Owns the TSR status bits (ENW, WIS, PIS, WRS) and the resulting interrupt and reset requests.

Parameters:
PIT_WIDTH, 32, width of PIT counter and reload register
RST_PULSE, 16, cycles wdRstReq stays asserted per watchdog reset event (min 1)

Ports:
CB  input  1  core clock; all state updates on rising edge
resetCore  input  1  synchronous, active-high reset
timerTic  input  1  one-cycle oscillator tic (delayed, synchronized)
freezeTimersNEG  input  1  0 = timers frozen (debug/JTAG)
tbTap  input  4  time-base tap bits for watchdog periods 2^17/2^21/2^25/2^29
tcrWp  input  2  watchdog period select, indexes tbTap
tcrWrc  input  2  watchdog reset control; 00 = no reset
tcrWie  input  1  watchdog interrupt enable
tcrPie  input  1  PIT interrupt enable
tcrAre  input  1  PIT auto-reload enable
mtPit  input  1  one-cycle mtSPR PIT strobe (already qualified by decode and ~sprHold)
sprData  input  PIT_WIDTH  mtSPR write data
tsrClr  input  4  write-1-to-clear strobes {ENW, WIS, PIS, WRS}
pitL2  output  PIT_WIDTH  current PIT value
tsrEnw, tsrWis, tsrPis  output  1 each  TSR status bits
tsrWrs  output  2  last watchdog reset type
pitIrq  output  1  tsrPis & tcrPie
wdIrq  output  1  tsrWis & tcrWie
wdRstReq  output  2  reset request type, valid for RST_PULSE cycles

Behaviour:
Reset (resetCore=1 on a clock edge):
- pitL2, reload register, tsrEnw, tsrWis, tsrPis, tsrWrs, wdRstReq and the pulse counter all go to 0.
- The tap history register loads the current tbTap.
- Reset mid-pulse terminates wdRstReq on the next edge.

PIT:
- mtPit: pitL2 <= sprData and reload <= sprData, regardless of freeze or tic. mtPit beats a coincident decrement.
- Decrement when timerTic & freezeTimersNEG & pitL2 != 0 & ~mtPit.
- 1->0 transition: sets tsrPis the same edge. If tcrAre=1, pitL2 <= reload instead of 0.
- pitL2 == 0: no decrement, no further PIS events. Auto-reload of a zero reload value yields a stuck 0.
- No wrap below zero.

Watchdog:
- A 4-bit tapPrev register samples tbTap every cycle.
- Event = tbTap[tcrWp] & ~tapPrev[tcrWp]. Per-tap history means a tcrWp change never creates a false event.
- The event is not re-qualified by freeze; a frozen time base produces no edges.
- State transitions on event, keyed by {ENW,WIS}:
  - 00 -> ENW=1
  - 10 -> WIS=1
  - 01 -> ENW=1
  - 11 -> if tcrWrc != 00 and the pulse counter is idle: tsrWrs <= tcrWrc, wdRstReq <= tcrWrc, counter <= RST_PULSE-1. Otherwise no change.
- Pulse counter: while nonzero it decrements each cycle and wdRstReq holds. wdRstReq returns to 00 the cycle after the counter reaches 0, i.e. exactly RST_PULSE cycles asserted.
- Events during an active pulse are ignored.

TSR:
- tsrClr[i] clears the bit on the next edge.
- A set event in the same cycle as a clear wins (bit stays/becomes 1).
- Clearing ENW/WIS does not affect an active pulse.

Interrupts:
- pitIrq and wdIrq are combinational from registered TSR bits and TCR enables, so they are 0 during and after reset.

Latency:
- All status and counter updates are visible one cycle after the causing input.

Test Plan:
- Reset, then mtPit sprData=3, tcrAre=0, tic every 4 cycles with freeze off -> pitL2 3,2,1,0; tsrPis=1 on the 1->0 edge; pitIrq=1 only when tcrPie=1; pitL2 stays 0.
- sprData=2, tcrAre=1, tic continuous -> pitL2 2,1,2,1...; PIS set at each reload; tsrClr[PIS] coincident with a reload leaves tsrPis=1.
- tcrWp=01, toggle tbTap[1] 0->1 four times, tcrWrc=10, RST_PULSE=16 -> ENW, WIS(wdIrq if tcrWie), then wdRstReq=10 for exactly 16 cycles; tsrWrs=10 persists.
- freezeTimersNEG=0 with tics -> pitL2 unchanged; mtPit during freeze still loads.
- tcrWp switched 00->11 while tbTap[3]=1 already -> no event; tbTap[0] edges after the switch are ignored.
- resetCore asserted mid wdRstReq pulse and with pitL2=5 -> next cycle all outputs 0.
